branch_imm24_encoder: RTL and testbench

//  Inverse of the 24-bit immediate sign extender: packs a branch target into the 24-bit signed

---
 rtl/branch_imm24_encoder.sv | 199 +++++++++++++++++++
 tb/tb_branch_imm24_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_imm24_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// branch_imm24_encoder
//
// Packs a branch target into the signed word-offset immediate of a B/BL
// instruction word. This is the inverse of the 24-bit immediate sign
// extender. The instruction builder/loader uses it before it writes
// instruction memory.
//
// Two-stage pipeline with a valid/ready handshake on each side:
//   S1 registers the 33-bit byte difference target - (pc + PC_OFFSET).
//   S2 registers the truncated word offset and the two error flags.
// Results are emitted even when a flag is set. A saturating counter
// records how many emitted results carried a flag.
//
// Parameters
//   IMM_W      width of the encoded signed word offset
//   PC_OFFSET  pipeline read-ahead added to pc before differencing (bytes)
//   CNT_W      width of the saturating error counter
//
// Ports
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high reset
//   in_valid      in   1      pc/target pair presented
//   in_ready      out  1      encoder accepts the pair this cycle
//   pc            in   32     byte address of the branch instruction
//   target        in   32     byte address of the branch destination
//   out_valid     out  1      result held on the outputs
//   out_ready     in   1      consumer accepts the result this cycle
//   imm24         out  IMM_W  encoded signed word offset, truncated
//   misaligned    out  1      target - pc is not a multiple of 4
//   out_of_range  out  1      word offset does not fit in signed IMM_W
//   err_count     out  CNT_W  emitted results with a flag set, saturating
// -----------------------------------------------------------------------------
module branch_imm24_encoder #(
  parameter int unsigned IMM_W     = 24,
  parameter int unsigned PC_OFFSET = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pc,
  input  logic [31:0]      target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IMM_W-1:0] imm24,
  output logic             misaligned,
  output logic             out_of_range,
  output logic [CNT_W-1:0] err_count
);

  // The byte difference is kept at 33 bits so that every 32-bit pc/target
  // pair gives an exact signed result. The word offset is that difference
  // shifted right by 2, which leaves 31 significant bits.
  localparam int unsigned DIFF_W = 33;
  localparam int unsigned WORD_W = DIFF_W - 2;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic [DIFF_W-1:0] s1_diff;

  logic              s2_valid;
  logic [IMM_W-1:0]  s2_imm;
  logic              s2_misaligned;
  logic              s2_out_of_range;

  logic [CNT_W-1:0]  err_count_q;

  // ---------------------------------------------------------------------------
  // Advance control
  //
  // S2 can take new data when it is empty or when its current result leaves
  // this cycle. S1 can take new data when it is empty or when its content
  // moves into S2. in_ready depends only on stage occupancy and out_ready,
  // never on in_valid. This keeps the upstream handshake free of loops.
  // ---------------------------------------------------------------------------
  logic s2_load;
  logic s1_load;
  logic in_fire;
  logic out_fire;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && s1_load;
  assign out_fire = s2_valid && out_ready;

  // ---------------------------------------------------------------------------
  // S1 datapath: signed byte difference
  //
  // Both operands are sign-extended to 33 bits. The read-ahead offset is added
  // to pc in the same width, so a pc near the top of the address space wraps
  // the same way the hardware PC does.
  // ---------------------------------------------------------------------------
  logic [DIFF_W-1:0] pc_ext;
  logic [DIFF_W-1:0] target_ext;
  logic [DIFF_W-1:0] diff_next;

  always_comb begin
    pc_ext     = {pc[31], pc} + DIFF_W'(PC_OFFSET);
    target_ext = {target[31], target};
    diff_next  = target_ext - pc_ext;
  end

  // NOTE: the S1 data register has no reset. It is only observed while
  // s1_valid is set, and s1_valid itself is reset. Leaving the reset off
  // the wide datapath saves a reset mux on every bit and does not change
  // any visible value.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_diff <= diff_next;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 datapath: word offset, truncation and flags
  //
  // The word offset is the arithmetic right shift of the difference by 2. It
  // fits in signed IMM_W only when every bit from the IMM_W-1 sign position
  // up to the top of the word equals that sign bit. Otherwise the truncated
  // immediate would decode to a different target.
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]       word;
  logic [WORD_W-IMM_W:0]   word_upper;
  logic [IMM_W-1:0]        imm_next;
  logic                    misaligned_next;
  logic                    out_of_range_next;

  always_comb begin
    word              = s1_diff[DIFF_W-1:2];
    word_upper        = word[WORD_W-1:IMM_W-1];
    imm_next          = word[IMM_W-1:0];
    misaligned_next   = |s1_diff[1:0];
    out_of_range_next = !((&word_upper) || !(|word_upper));
  end

  // ---------------------------------------------------------------------------
  // Sequential control and output registers
  //
  // Reset overrides everything and drops both stages. Any pair in flight is
  // discarded without being emitted. The output registers reset to zero
  // because they are visible on the ports right after reset.
  // ---------------------------------------------------------------------------
  logic flagged;
  logic err_sat;

  assign flagged = s2_misaligned || s2_out_of_range;
  assign err_sat = &err_count_q;

  // NOTE: every register in this block is assigned with <=, so each branch
  // reads the values from the previous clock edge. That holds no matter how
  // the statements below are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      s2_imm          <= '0;
      s2_misaligned   <= 1'b0;
      s2_out_of_range <= 1'b0;
      err_count_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
      end

      if (s2_load) begin
        s2_valid <= s1_valid;
        // The output fields only change when a new result moves into S2.
        // When S2 empties, the last result stays on the outputs with
        // out_valid low.
        if (s1_valid) begin
          s2_imm          <= imm_next;
          s2_misaligned   <= misaligned_next;
          s2_out_of_range <= out_of_range_next;
        end
      end

      // Count only results that actually leave the encoder, so a stalled
      // result is counted once. The counter stops at all-ones.
      if (out_fire && flagged && !err_sat) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid    = s2_valid;
  assign imm24        = s2_imm;
  assign misaligned   = s2_misaligned;
  assign out_of_range = s2_out_of_range;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_branch_imm24_encoder.sv
`timescale 1ns/1ps
module tb_branch_imm24_encoder;

  typedef struct packed {
    logic [23:0] imm;
    logic        mis;
    logic        oor;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] imm24;
  logic        misaligned;
  logic        out_of_range;
  logic [7:0]  err_count;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t q[$];
  int   model_err = 0;
  logic [23:0] last_imm = '0;

  // Values saved by the monitor at the previous negedge, used for the stall checks.
  logic        prev_stall = 1'b0;
  logic [23:0] prev_imm;
  logic        prev_mis;
  logic        prev_oor;
  logic        prev_valid;

  branch_imm24_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc           (pc),
    .target       (target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .imm24        (imm24),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. It uses wide signed arithmetic and a numeric range test.
  function automatic exp_t model(input logic [31:0] p, input logic [31:0] t);
    exp_t        e;
    longint      d;
    logic [32:0] d33;
    longint      ds;
    longint      w;
    d     = longint'($signed(t)) - longint'($signed(p)) - 64'sd8;
    d33   = d[32:0];
    ds    = longint'($signed(d33));
    w     = ds >>> 2;
    e.imm = w[23:0];
    e.mis = (ds[1:0] != 2'b00);
    e.oor = (w > 64'sd8388607) || (w < -64'sd8388608);
    return e;
  endfunction

  // Monitor and scoreboard. Sampling on the negedge means inputs and outputs
  // are stable, and each handshake seen here is the transfer at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    check("err_count", err_count, model_err);
    if (prev_stall && !reset) begin
      check("stall_valid", out_valid, prev_valid);
      check("stall_imm", imm24, prev_imm);
      check("stall_mis", misaligned, prev_mis);
      check("stall_oor", out_of_range, prev_oor);
    end
    if (reset) begin
      q.delete();
      model_err  = 0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) q.push_back(model(pc, target));
      if (out_valid && out_ready) begin
        check("out_has_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("imm24", imm24, e.imm);
          check("misaligned", misaligned, e.mis);
          check("out_of_range", out_of_range, e.oor);
          last_imm = imm24;
          if ((e.mis || e.oor) && model_err < 255) model_err++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_imm   = imm24;
      prev_mis   = misaligned;
      prev_oor   = out_of_range;
    end
  end

  // Entered at posedge+1. Holds the pair until it is accepted and returns at
  // posedge+1 just after the accepting edge. in_valid stays high for back-to-back use.
  task automatic drive(input logic [31:0] p, input logic [31:0] t);
    bit ok = 1'b0;
    pc = p;
    target = t;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] t4_pc [6];
  logic [31:0] t4_tg [6];

  initial begin
    t4_pc = '{32'h0000_1000, 32'h0000_2000, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_8000, 32'h0000_0040};
    t4_tg = '{32'h0000_2000, 32'h0000_1000, 32'h0000_0003, 32'h0000_0010, 32'h0800_0000, 32'h0000_0048};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pc = '0; target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_imm24", imm24, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_out_of_range", out_of_range, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: zero displacement, two-cycle latency
    @(posedge clk); #1;
    drive(32'h100, 32'h100);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_imm24", imm24, 24'hFFFFFE);
    @(posedge clk); #1;

    // 2: short backward branch, sign-extension round trip
    drive(32'h200, 32'h1FC);
    idle(4);
    check("roundtrip_sext", {{8{last_imm[23]}}, last_imm}, 32'hFFFF_FFFD);

    // 3: range boundaries and misalignment
    drive(32'h0, 32'h0200_0004);
    drive(32'h0, 32'h0200_0008);
    drive(32'h104, 32'h102);
    idle(5);
    check("t3_err_count", err_count, 2);

    // 4: six pairs back to back, consumer stalls for three cycles
    fork
      begin
        for (int i = 0; i < 6; i++) drive(t4_pc[i], t4_tg[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    check("t4_drained", q.size(), 0);

    // Random burst with random backpressure
    fork
      begin
        for (int i = 0; i < 24; i++)
          drive($urandom_range(0, 3) == 0 ? $urandom() : $urandom_range(0, 32'h0400_0000),
                $urandom_range(0, 32'h0400_0000));
        in_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("rand_drained", q.size(), 0);

    // 5: reset with both stages full
    out_ready = 1'b0;
    drive(32'h0, 32'h0400_0000);
    drive(32'h10, 32'h13);
    pc = 32'h20; target = 32'h40; in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    idle(5);
    @(negedge clk);
    check("mid_rst_no_stale", out_valid, 0);
    @(posedge clk); #1;

    // 6: counter saturation
    for (int i = 0; i < 300; i++) drive(32'h0, 32'h0400_0000);
    idle(5);
    check("err_saturated", err_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
